// File: rtl/fpnew_pkg.sv
// Shared fpnew types and per-format geometry helpers.
package fpnew_pkg;

    localparam int unsigned NUM_FP_FORMATS = 5;
    localparam int unsigned FP_FORMAT_BITS = 3;

    typedef enum logic [FP_FORMAT_BITS-1:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [1:0] {
        QNAN    = 2'd0,
        INF     = 2'd1,
        ZERO    = 2'd2,
        MAXNORM = 2'd3
    } special_kind_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    function automatic int unsigned exp_bits(fp_format_e fmt);
        case (fmt)
            FP32:    return 8;
            FP64:    return 11;
            FP16:    return 5;
            FP8:     return 5;
            FP16ALT: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        case (fmt)
            FP32:    return 23;
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

    function automatic int unsigned max_width(logic [NUM_FP_FORMATS-1:0] mask);
        int unsigned w;
        w = 0;
        for (int unsigned f = 0; f < NUM_FP_FORMATS; f++) begin
            if (mask[f] && fp_width(fp_format_e'(FP_FORMAT_BITS'(f))) > w) begin
                w = fp_width(fp_format_e'(FP_FORMAT_BITS'(f)));
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/fpnew_pipe_stage.sv
// One valid/ready register slice with synchronous flush; payload loads only on handshake.
module fpnew_pipe_stage #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    assign ready_o = ready_i | ~valid_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (ready_o) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fpnew_special_pipe.sv
// Pipelined generator of IEEE-754 special values (qNaN, inf, zero, max-normal)
// for every enabled fpnew format, NaN-boxed to WIDTH, with matching status flags.
module fpnew_special_pipe
    import fpnew_pkg::*;
#(
    parameter int unsigned                   WIDTH       = 64,
    parameter logic [NUM_FP_FORMATS-1:0]     FpFmtMask   = 5'b11111,
    parameter bit                            NanBox      = 1'b1,
    parameter int unsigned                   NumPipeRegs = 1,
    parameter int unsigned                   TagWidth    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [FP_FORMAT_BITS-1:0] fmt_i,
    input  logic [1:0]                kind_i,
    input  logic                      use_sign_i,
    input  logic                      sign_i,
    input  logic                      invalid_i,
    input  logic                      overflow_i,
    input  logic [TagWidth-1:0]       tag_i,
    output logic [WIDTH-1:0]          result_o,
    output logic [4:0]                status_o,
    output logic [TagWidth-1:0]       tag_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      busy_o
);

    localparam int unsigned StatusWidth  = $bits(status_t);
    localparam int unsigned PayloadWidth = WIDTH + StatusWidth + TagWidth;

    // Built one bit wider than WIDTH so a full-width format shifts cleanly.
    function automatic logic [WIDTH-1:0] encode(input fp_format_e fmt,
                                                input special_kind_e kind,
                                                input logic s);
        int unsigned     e, m;
        logic [WIDTH:0]  one, body;
        e    = exp_bits(fmt);
        m    = man_bits(fmt);
        one  = (WIDTH+1)'(1);
        body = '0;
        case (kind)
            QNAN:    body = (((one << e) - one) << m) | (one << (m - 1));
            INF:     body = ((one << e) - one) << m;
            ZERO:    body = '0;
            MAXNORM: body = (((one << e) - (WIDTH+1)'(2)) << m) | ((one << m) - one);
            default: body = '0;
        endcase
        if (s && kind != QNAN) begin
            body = body | (one << (e + m));
        end
        if (NanBox) begin
            body = body | ~((one << fp_width(fmt)) - one);
        end
        return body[WIDTH-1:0];
    endfunction

    logic              fmt_ok_c;
    logic [WIDTH-1:0]  result_c;
    status_t           status_c;
    logic              ovf_kind_c;

    always_comb begin
        fmt_ok_c = 1'b0;
        result_c = '0;
        for (int unsigned f = 0; f < NUM_FP_FORMATS; f++) begin
            if (FpFmtMask[f] && fmt_i == FP_FORMAT_BITS'(f)) begin
                fmt_ok_c = 1'b1;
                result_c = encode(fp_format_e'(FP_FORMAT_BITS'(f)),
                                  special_kind_e'(kind_i),
                                  use_sign_i & sign_i);
            end
        end
    end

    assign ovf_kind_c = overflow_i & (special_kind_e'(kind_i) == INF ||
                                      special_kind_e'(kind_i) == MAXNORM);

    always_comb begin
        status_c    = '0;
        status_c.nv = invalid_i | ~fmt_ok_c;
        status_c.of = ovf_kind_c;
        status_c.nx = ovf_kind_c;
    end

    logic [NumPipeRegs:0]    stg_valid;
    logic [NumPipeRegs:0]    stg_ready;
    logic [PayloadWidth-1:0] stg_data [NumPipeRegs+1];

    assign stg_valid[0]           = valid_i;
    assign stg_data[0]            = {result_c, status_c, tag_i};
    assign stg_ready[NumPipeRegs] = ready_i;
    assign ready_o                = stg_ready[0];

    // Register chain; zero stages leaves the encoder combinational end to end.
    for (genvar k = 0; k < NumPipeRegs; k++) begin : g_stage
        fpnew_pipe_stage #(
            .Width(PayloadWidth)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .valid_i (stg_valid[k]),
            .ready_o (stg_ready[k]),
            .data_i  (stg_data[k]),
            .valid_o (stg_valid[k+1]),
            .ready_i (stg_ready[k+1]),
            .data_o  (stg_data[k+1])
        );
    end

    assign valid_o                      = stg_valid[NumPipeRegs];
    assign {result_o, status_o, tag_o}  = stg_data[NumPipeRegs];
    assign busy_o                       = |(stg_valid >> 1);

endmodule
